data_mem_responder: RTL and testbench

Responder end of the SCC core's data-memory port: accepts one load/store request at a time from the core, waits a parameterised number of cycles, then returns read data or a write acknowledgement with a 2-bit error code. It sits between `scc` and the data storage in `scc_f25_top`. It gives the core a ready/valid contract with real wait states in place of a zero-latency array, and stops accepting new requests once the core raises halt.

---
 rtl/scc_pkg.sv | 19 +
 rtl/dm_word_ram.sv | 33 +++
 rtl/data_mem_responder.sv | 144 ++++++++++++++
 tb/tb_data_mem_responder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/scc_pkg.sv
// Shared definitions for the SCC data-memory responder.
//   DATA_W        : data word width
//   ERR_*         : 2-bit response error codes
//   state_e       : responder FSM state encoding
package scc_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dm_word_ram.sv
// Single-port synchronous word array, DEPTH_WORDS x DATA_W, no reset.
//   clk   : rising-edge clock
//   en    : access enable (read and optional write on this edge)
//   we    : write enable, qualified by en
//   addr  : word index
//   wdata : write data
//   rdata : registered read data (value before any write on the same edge)
module dm_word_ram
  import scc_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Responder for the SCC core data-memory port. Accepts one load/store at a
// time, waits LATENCY cycles, then performs the access and holds the
// response until the core takes it.
//   clk, rst (async, active-low), clk_en (global hold)
//   halt_f                      : core halted, blocks new acceptance
//   req_valid/req_ready         : request handshake (req_ready combinational)
//   req_write/req_addr/req_wdata: request fields, sampled at accept only
//   resp_valid/resp_ready       : response handshake
//   resp_rdata/resp_err         : load data and error code
//   busy                        : transaction in flight (WAIT or RESP)
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no transaction, may accept when enabled and not halted
// ST_WAIT | counting down latency; access performed when counter is 0
// ST_RESP | response presented, held until resp_ready
module data_mem_responder
  import scc_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              halt_f,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [1:0]        resp_err,
  output logic              busy
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              resp_valid_q;
  logic [1:0]        resp_err_q;
  logic              rd_ok_q;
  logic              accept;
  logic              access;
  logic [1:0]        err_d;
  logic [DATA_W-1:0] ram_rdata;

  assign req_ready = clk_en && (state_q == ST_IDLE) && !halt_f;
  assign busy      = (state_q != ST_IDLE);

  // Misalignment is checked first so a misaligned out-of-range address
  // still reports 01.
  always_comb begin
    err_d = ERR_OK;
    if (addr_q[1:0] != 2'b00) begin
      err_d = ERR_MISALIGN;
    end else if (addr_q[31:2] >= 30'(DEPTH_WORDS)) begin
      err_d = ERR_RANGE;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    access  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          accept  = 1'b1;
          cnt_d   = 4'(LATENCY);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      wr_q         <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= ERR_OK;
      rd_ok_q      <= 1'b0;
    end else if (clk_en) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (access) begin
        resp_valid_q <= 1'b1;
        resp_err_q   <= err_d;
        rd_ok_q      <= !wr_q && (err_d == ERR_OK);
      end else if (state_q == ST_RESP && resp_ready) begin
        resp_valid_q <= 1'b0;
      end
    end
  end

  // The RAM only clocks on the access edge, so its read register holds the
  // loaded word for the whole RESP phase.
  dm_word_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk   (clk),
    .en    (clk_en && access),
    .we    (wr_q && (err_d == ERR_OK)),
    .addr  (addr_q[2 +: AW]),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = rd_ok_q ? ram_rdata : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clk_en = 1'b1;
  logic        halt_f = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  data_mem_responder #(
    .DEPTH_WORDS (256),
    .LATENCY     (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .halt_f     (halt_f),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  // Drive one request for a single edge, then scramble the fields so any
  // late sampling by the DUT shows up.
  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write = ~w;
    req_addr  = 32'h0000_0044;
    req_wdata = 32'h5A5A_5A5A;
  endtask

  // Count edges until resp_valid is seen, bounded.
  task automatic wait_resp(output int n);
    n = 0;
    while (!resp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic take_resp();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    vectors++; if (resp_rdata !== 32'd0) begin miscompares++; $display("FAIL reset_rdata got %h want 0", resp_rdata); end
    vectors++; if (resp_err !== 2'b00) begin miscompares++; $display("FAIL reset_err got %b want 00", resp_err); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    int n;
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL sl_ready got %b want 1", req_ready); end
    send(1'b1, 32'h10, 32'hDEADBEEF);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL sl_busy got %b want 1", busy); end
    wait_resp(n);
    vectors++; if (n !== 3) begin miscompares++; $display("FAIL store_latency got %0d want 3", n); end
    vectors++; if (resp_err !== 2'b00) begin miscompares++; $display("FAIL store_err got %b want 00", resp_err); end
    vectors++; if (resp_rdata !== 32'd0) begin miscompares++; $display("FAIL store_rdata got %h want 0", resp_rdata); end
    take_resp();
    vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL store_done_valid got %b want 0", resp_valid); end
    send(1'b0, 32'h10, 32'h0);
    wait_resp(n);
    vectors++; if (n !== 3) begin miscompares++; $display("FAIL load_latency got %0d want 3", n); end
    vectors++; if (resp_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL load_rdata got %h want deadbeef", resp_rdata); end
    vectors++; if (resp_err !== 2'b00) begin miscompares++; $display("FAIL load_err got %b want 00", resp_err); end
    take_resp();
  endtask

  task automatic test_errors();
    int n;
    send(1'b1, 32'h0, 32'h11111111);
    wait_resp(n);
    take_resp();
    send(1'b0, 32'h6, 32'h0);
    wait_resp(n);
    vectors++; if (resp_err !== 2'b01) begin miscompares++; $display("FAIL misalign_err got %b want 01", resp_err); end
    vectors++; if (resp_rdata !== 32'd0) begin miscompares++; $display("FAIL misalign_rdata got %h want 0", resp_rdata); end
    take_resp();
    send(1'b1, 32'h400, 32'h12345678);
    wait_resp(n);
    vectors++; if (resp_err !== 2'b10) begin miscompares++; $display("FAIL range_err got %b want 10", resp_err); end
    take_resp();
    send(1'b1, 32'h402, 32'h87654321);
    wait_resp(n);
    vectors++; if (resp_err !== 2'b01) begin miscompares++; $display("FAIL priority_err got %b want 01", resp_err); end
    take_resp();
    send(1'b0, 32'h0, 32'h0);
    wait_resp(n);
    vectors++; if (resp_rdata !== 32'h11111111) begin miscompares++; $display("FAIL word0_rdata got %h want 11111111", resp_rdata); end
    vectors++; if (resp_err !== 2'b00) begin miscompares++; $display("FAIL word0_err got %b want 00", resp_err); end
    take_resp();
  endtask

  task automatic test_backpressure();
    int n;
    send(1'b0, 32'h10, 32'h0);
    wait_resp(n);
    for (int i = 0; i < 5; i++) begin
      vectors++; if (resp_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid cyc %0d got %b want 1", i, resp_valid); end
      vectors++; if (resp_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL bp_rdata cyc %0d got %h want deadbeef", i, resp_rdata); end
      vectors++; if (resp_err !== 2'b00) begin miscompares++; $display("FAIL bp_err cyc %0d got %b want 00", i, resp_err); end
      vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL bp_req_ready cyc %0d got %b want 0", i, req_ready); end
      @(posedge clk); #1;
    end
    take_resp();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL bp_idle_busy got %b want 0", busy); end
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL bp_idle_ready got %b want 1", req_ready); end
  endtask

  task automatic test_halt();
    int n;
    send(1'b1, 32'h20, 32'hCAFEF00D);
    halt_f = 1'b1;
    wait_resp(n);
    vectors++; if (n !== 3) begin miscompares++; $display("FAIL halt_latency got %0d want 3", n); end
    vectors++; if (resp_err !== 2'b00) begin miscompares++; $display("FAIL halt_err got %b want 00", resp_err); end
    take_resp();
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h20;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL halt_ready cyc %0d got %b want 0", i, req_ready); end
      @(posedge clk); #1;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL halt_busy cyc %0d got %b want 0", i, busy); end
    end
    req_valid = 1'b0;
    halt_f = 1'b0;
    send(1'b0, 32'h20, 32'h0);
    wait_resp(n);
    vectors++; if (resp_rdata !== 32'hCAFEF00D) begin miscompares++; $display("FAIL halt_store_rdata got %h want cafef00d", resp_rdata); end
    take_resp();
  endtask

  task automatic test_clk_en();
    int n;
    clk_en = 1'b0;
    #1;
    vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL ce_idle_ready got %b want 0", req_ready); end
    clk_en = 1'b1;
    send(1'b0, 32'h10, 32'h0);
    clk_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (resp_valid !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL ce_frozen got valid=%b busy=%b want 0 1", resp_valid, busy); end
    clk_en = 1'b1;
    wait_resp(n);
    vectors++; if (n !== 3) begin miscompares++; $display("FAIL ce_latency_after_hold got %0d want 3", n); end
    vectors++; if (resp_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL ce_rdata got %h want deadbeef", resp_rdata); end
    take_resp();
  endtask

  task automatic test_rst_mid();
    int n;
    send(1'b1, 32'h30, 32'h0);
    wait_resp(n);
    take_resp();
    send(1'b0, 32'h10, 32'h0);
    wait_resp(n);
    take_resp();
    send(1'b1, 32'h30, 32'hFFFFFFFF);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_valid got %b want 0", resp_valid); end
    vectors++; if (resp_rdata !== 32'd0) begin miscompares++; $display("FAIL rst_mid_rdata got %h want 0", resp_rdata); end
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_mid_ready got %b want 1", req_ready); end
    #2;
    rst = 1'b1;
    @(posedge clk); #1;
    send(1'b0, 32'h30, 32'h0);
    wait_resp(n);
    vectors++; if (resp_rdata !== 32'h00000000) begin miscompares++; $display("FAIL rst_mid_prior got %h want 0", resp_rdata); end
    vectors++; if (resp_valid !== 1'b1) begin miscompares++; $display("FAIL rst_mid_reload_valid got %b want 1", resp_valid); end
    take_resp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store_load();
    test_errors();
    test_backpressure();
    test_halt();
    test_clk_en();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
